// File: rtl/demux9_pkg.sv
// Shared widths, channel indices and occupancy encoding for the 9-bit 1:4 demux.
package demux9_pkg;
    localparam int W     = 9;
    localparam int NCH   = 4;
    localparam int SELW  = 2;
    localparam int DEPTH = 2;

    localparam logic [SELW-1:0] CH0 = 2'd0;
    localparam logic [SELW-1:0] CH1 = 2'd1;
    localparam logic [SELW-1:0] CH2 = 2'd2;
    localparam logic [SELW-1:0] CH3 = 2'd3;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;
endpackage

// File: rtl/demux9_chan_buf.sv
// Two-entry per-channel FIFO kept as head/tail registers; head is the output word.
module demux9_chan_buf
    import demux9_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic [W-1:0] head,
    output logic         valid
);
    logic [1:0]   occ_q, occ_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push_ok, pop_ok;

    assign full    = (occ_q == OCC_FULL);
    assign valid   = (occ_q != OCC_EMPTY);
    assign head    = head_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && valid;

    // head_q is left untouched on the last pop so the output holds its old value
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == OCC_EMPTY) begin
                    head_d = din;
                    occ_d  = OCC_ONE;
                end else begin
                    tail_d = din;
                    occ_d  = OCC_FULL;
                end
            end
            2'b01: begin
                if (occ_q == OCC_FULL) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end else begin
                    occ_d  = OCC_EMPTY;
                end
            end
            2'b11: begin
                head_d = din;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/demux9_4_buf.sv
// 1:4 word demux with a 2-deep buffer per channel and an accept counter.
// DEMUX9_AUTOSEQ_EN adds seq_mode and a round-robin destination pointer.
module demux9_4_buf
    import demux9_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
`ifdef DEMUX9_AUTOSEQ_EN
    input  logic             seq_mode,
`endif
    input  logic [W-1:0]     din,
    input  logic [SELW-1:0]  sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [NCH*W-1:0] dout,
    output logic [NCH-1:0]   dout_valid,
    input  logic [NCH-1:0]   dout_ready,
    output logic [7:0]       acc_cnt
);
    logic [SELW-1:0]         dest;
    logic                    accept;
    logic [NCH-1:0]          full;
    logic [NCH-1:0][W-1:0]   heads;
    logic [7:0]              acc_cnt_q, acc_cnt_d;

`ifdef DEMUX9_AUTOSEQ_EN
    logic [SELW-1:0] rr_q, rr_d;

    always_comb begin
        dest = seq_mode ? rr_q : sel;
        rr_d = rr_q;
        if (seq_mode && accept) rr_d = rr_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= CH0;
        else     rr_q <= rr_d;
    end
`else
    always_comb dest = sel;
`endif

    // ready looks only at the destination's fill state, never at dout_ready
    assign din_ready = !full[dest];
    assign accept    = din_valid && din_ready;

    always_comb acc_cnt_d = acc_cnt_q + {7'd0, accept};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_cnt_q <= '0;
        else     acc_cnt_q <= acc_cnt_d;
    end
    assign acc_cnt = acc_cnt_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        demux9_chan_buf u_buf (
            .clk   (clk),
            .rst   (rst),
            .push  (accept && (dest == SELW'(g))),
            .din   (din),
            .pop   (dout_ready[g]),
            .full  (full[g]),
            .head  (heads[g]),
            .valid (dout_valid[g])
        );
    end

    assign dout = heads;
endmodule

// File: tb/tb_demux9_4_buf.sv
// Bench for demux9_4_buf: hand-written vector table plus per-channel scoreboard model.
module tb_demux9_4_buf;
    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  din;
    logic [1:0]  sel;
    logic        din_valid;
    logic        din_ready;
    logic [35:0] dout;
    logic [3:0]  dout_valid;
    logic [3:0]  dout_ready;
    logic [7:0]  acc_cnt;
`ifdef DEMUX9_AUTOSEQ_EN
    logic        seq_mode;
`endif

    demux9_4_buf dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DEMUX9_AUTOSEQ_EN
        .seq_mode   (seq_mode),
`endif
        .din        (din),
        .sel        (sel),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .acc_cnt    (acc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] din;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] rdy;
        logic       exp_ready;
        logic [3:0] exp_vld;
        logic [7:0] exp_acc;
    } vec_t;

    typedef logic [8:0] word_q_t[$];
    word_q_t    mq [4];
    logic [7:0] m_acc;
    logic [1:0] m_rr;
    int         n_cmp = 0;
    int         n_err = 0;
    vec_t       tbl [19];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_dest();
`ifdef DEMUX9_AUTOSEQ_EN
        return seq_mode ? m_rr : sel;
`else
        return sel;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mq[k].delete();
        m_acc = 8'd0;
        m_rr  = 2'd0;
    endtask

    // Compare pre-edge outputs against the model, then advance the model by one edge.
    task automatic step(input vec_t v, input bit use_exp);
        logic [1:0] d;
        logic       er;
        @(negedge clk);
        din = v.din; sel = v.sel; din_valid = v.valid; dout_ready = v.rdy;
        #1;
        d  = m_dest();
        er = (mq[d].size() < 2);
        chk("din_ready", int'(din_ready), int'(er));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dout_valid[%0d]", k), int'(dout_valid[k]), int'(mq[k].size() > 0));
            if (mq[k].size() > 0)
                chk($sformatf("dout[%0d]", k), int'(dout[k*9 +: 9]), int'(mq[k][0]));
        end
        chk("acc_cnt", int'(acc_cnt), int'(m_acc));
        if (use_exp) begin
            chk("tbl_ready", int'(din_ready), int'(v.exp_ready));
            chk("tbl_vld", int'(dout_valid), int'(v.exp_vld));
            chk("tbl_acc", int'(acc_cnt), int'(v.exp_acc));
        end
        for (int k = 0; k < 4; k++)
            if (mq[k].size() > 0 && dout_ready[k]) void'(mq[k].pop_front());
        if (din_valid && er) begin
            mq[d].push_back(din);
            m_acc++;
`ifdef DEMUX9_AUTOSEQ_EN
            if (seq_mode) m_rr++;
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0;
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        //           din     sel  vld  rdy      rdy  vld      acc
        tbl[0]  = '{9'h000, 2'd0, 0, 4'b1111, 1, 4'b0000, 8'd0};
        tbl[1]  = '{9'h1A5, 2'd2, 1, 4'b1111, 1, 4'b0000, 8'd0};
        tbl[2]  = '{9'h000, 2'd0, 0, 4'b1111, 1, 4'b0100, 8'd1};
        tbl[3]  = '{9'h000, 2'd0, 0, 4'b1101, 1, 4'b0000, 8'd1};
        tbl[4]  = '{9'h001, 2'd1, 1, 4'b1101, 1, 4'b0000, 8'd1};
        tbl[5]  = '{9'h002, 2'd1, 1, 4'b1101, 1, 4'b0010, 8'd2};
        tbl[6]  = '{9'h003, 2'd1, 1, 4'b1101, 0, 4'b0010, 8'd3};
        tbl[7]  = '{9'h003, 2'd0, 0, 4'b1101, 1, 4'b0010, 8'd3};
        tbl[8]  = '{9'h003, 2'd1, 0, 4'b1111, 0, 4'b0010, 8'd3};
        tbl[9]  = '{9'h000, 2'd1, 0, 4'b1111, 1, 4'b0010, 8'd3};
        tbl[10] = '{9'h000, 2'd0, 0, 4'b1111, 1, 4'b0000, 8'd3};
        tbl[11] = '{9'h0AA, 2'd3, 1, 4'b0111, 1, 4'b0000, 8'd3};
        tbl[12] = '{9'h0FF, 2'd3, 1, 4'b1111, 1, 4'b1000, 8'd4};
        tbl[13] = '{9'h000, 2'd3, 0, 4'b0111, 1, 4'b1000, 8'd5};
        tbl[14] = '{9'h000, 2'd3, 0, 4'b1111, 1, 4'b1000, 8'd5};
        tbl[15] = '{9'h000, 2'd0, 0, 4'b1111, 1, 4'b0000, 8'd5};
        tbl[16] = '{9'h111, 2'd0, 1, 4'b1110, 1, 4'b0000, 8'd5};
        tbl[17] = '{9'h122, 2'd0, 1, 4'b1110, 1, 4'b0001, 8'd6};
        tbl[18] = '{9'h133, 2'd0, 1, 4'b1110, 0, 4'b0001, 8'd7};

        rst = 1'b1; din = '0; sel = '0; din_valid = 1'b0; dout_ready = 4'hF;
`ifdef DEMUX9_AUTOSEQ_EN
        seq_mode = 1'b0;
`endif
        model_reset();
        @(negedge clk); #1;
        chk("rst_vld", int'(dout_valid), 0);
        chk("rst_acc", int'(acc_cnt), 0);
        chk("rst_dout", int'(dout), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) step(tbl[i], 1'b1);
        chk("ch3_head_after_pushpop", int'(dout[27 +: 9]), 9'h0FF);

        // ch0 holds two words; reset asserted mid-cycle must clear at once
        @(posedge clk); #2;
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_vld", int'(dout_valid), 0);
        chk("async_rst_acc", int'(acc_cnt), 0);
        chk("async_rst_ready", int'(din_ready), 1);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // acc_cnt wrap: 256 accepts from zero
        for (int i = 0; i < 255; i++) begin
            v = '{9'(i), 2'd0, 1'b1, 4'hF, 1'b1, 4'h0, 8'd0};
            step(v, 1'b0);
        end
        v = '{9'h1FF, 2'd0, 1'b1, 4'hF, 1'b1, 4'h0, 8'd0};
        step(v, 1'b0);
        chk("acc_255", int'(acc_cnt), 255);
        v.valid = 1'b0;
        step(v, 1'b0);
        chk("acc_wrap", int'(acc_cnt), 0);

        for (int i = 0; i < 400; i++) begin
            v.din   = 9'($urandom);
            v.sel   = 2'($urandom);
            v.valid = 1'($urandom);
            v.rdy   = 4'($urandom);
            step(v, 1'b0);
        end

`ifdef DEMUX9_AUTOSEQ_EN
        do_reset();
        seq_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v = '{9'h010 + 9'(i), 2'd3, 1'b1, 4'hF, 1'b1, 4'h0, 8'd0};
            step(v, 1'b0);
            if (i > 0) chk("seq_route", int'(dout_valid), int'(4'b0001 << ((i - 1) % 4)));
        end
        v = '{9'h020, 2'd0, 1'b1, 4'hF, 1'b1, 4'h0, 8'd0};
        step(v, 1'b0);
        chk("seq_route_last", int'(dout_valid), int'(4'b0010));
        chk("seq_acc", int'(acc_cnt), 6);
        v.valid = 1'b0;
        step(v, 1'b0);
        chk("seq_rr_is_2", int'(dout_valid), int'(4'b0100));
        seq_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demux9_4_buf.md
Name: demux9_4_buf

Overview:
- Inverse of the 4:1 9-bit word selector: takes one 9-bit input word stream and steers each word to one of four output channels by a 2-bit select.
- Each channel holds words in a 2-entry buffer with an independent valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between a single word producer (e.g. bus/UART byte+flag source) and four consumer sub-blocks in the lab datapath.

Parameters:
- W, 9, data word width in bits.
- NCH, 4, number of output channels (fixed at 4; select width 2).
- DEPTH, 2, entries per channel buffer (fixed at 2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  input data word.
- sel  input  2  destination channel for din; 0→ch0, 1→ch1, 2→ch2, 3→ch3.
- din_valid  input  1  din/sel valid this cycle.
- din_ready  output  1  block can accept din this cycle.
- dout  output  NCH*W  packed channel heads; ch k at bits [k*W +: W].
- dout_valid  output  NCH  per-channel head valid.
- dout_ready  input  NCH  per-channel consumer ready.
- acc_cnt  output  8  count of accepted input words, wraps 255→0.

Behaviour:
- Reset (async assert, sync-safe release): all buffers empty; dout_valid=0; dout=0; acc_cnt=0; din_ready reflects empty buffers (1) once rst is low.
- Accept = din_valid & din_ready. Pop on ch k = dout_valid[k] & dout_ready[k].
- din_ready = !full[dest], where dest = sel (or the sequencer, see Optional Feature). Combinational from sel/dest and buffer state only; never depends on dout_ready. There is no same-cycle pass-through.
- Latency: a word accepted at edge N appears at dout[k] with dout_valid[k]=1 after edge N, unless older words are ahead of it.
- Per channel, FIFO order is preserved. Occupancy is 0, 1 or 2.
  - Push only: occupancy +1.
  - Pop only: occupancy −1.
  - Push and pop in the same cycle at occupancy 1: occupancy stays 1, and the head becomes the new word.
  - A push at occupancy 2 cannot occur, because din_ready=0.
- dout[k] holds the last head value when empty. Only dout_valid[k] is meaningful.
- Words are never dropped or duplicated. din_valid with din_ready=0 is a stall, not an error; the producer holds din/sel.
- acc_cnt increments by 1 on every accept and wraps modulo 256.
- Asserting rst mid-transfer flushes all buffers immediately. In-flight words are lost by design.

Optional Feature:
- Macro: DEMUX9_AUTOSEQ_EN.
- Defined:
  - Adds input port seq_mode (1 bit) and an internal 2-bit round-robin pointer rr (reset 0).
  - When seq_mode=1, dest=rr and sel is ignored. rr increments on each accept and wraps 3→0.
  - When seq_mode=0, dest=sel and rr holds its value.
- Undefined: no seq_mode port and no rr; dest=sel always.

Decomposition:
- Shared package/include demux9_pkg:
  - W=9, NCH=4, SELW=2, DEPTH=2.
  - Channel index constants CH0..CH3.
  - Occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
- Sub-module demux9_chan_buf: one 2-entry FIFO with push/din/full and head/valid/pop, instantiated NCH times.
- Top level: select decode, din_ready mux, acc_cnt, and optional sequencer.

Test Plan:
- Reset then idle → dout_valid=0000, acc_cnt=0, din_ready=1.
- Write 9'h1A5 sel=2, all dout_ready=1 → next cycle dout_valid=0100 and ch2 data=9'h1A5; pop next edge; acc_cnt=1.
- ch1 dout_ready=0; push 9'h001, 9'h002 to sel=1 → din_ready=0 while sel=1 and stays 1 for sel=0. Release ready → ch1 outputs 001 then 002 in order.
- At ch3 occupancy 1, push 9'h0FF and pop in the same cycle → occupancy stays 1 and head=9'h0FF.
- Assert rst mid-burst with ch0 holding 2 words → dout_valid=0000 immediately (async) and acc_cnt=0.
- DEMUX9_AUTOSEQ_EN, seq_mode=1, push 9'h010..9'h015 → routed to ch0,1,2,3,0,1; rr ends at 2 and acc_cnt=6.
